uart_mem_loader: RTL and testbench

Serial program loader that sits directly upstream of the 64K×16 dual-port program/data memory and drives its port B write interface. On `start` it receives a length-prefixed image over a UART line (8N1), assembles big-endian 16-bit words and writes them to consecutive memory addresses from `BASE_ADDR`. This lets a new game/program image be loaded without re-synthesising the memory initialisation file. The CPU is held off by the system while `busy` is high.

---
 rtl/uart_mem_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// ---------------------------------------------------------------------------
// uart_mem_loader: receives a length-prefixed 8N1 image and writes 16-bit
// big-endian words to memory port B. Optional: UART_LOADER_CHECKSUM_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_mem_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        uart_rx,
  input  logic        start,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic        frame_error,
  output logic        checksum_error
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_DONE, LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_WRITE
`ifdef UART_LOADER_CHECKSUM_EN
    , LD_CHECK
`endif
  } ld_state_t;

  // receiver state
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d, stop_err_q, stop_err_d;

  // loader state
  ld_state_t        state_q, state_d;
  logic [15:0]      len_q, len_d, wc_q, wc_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]       hi_q, hi_d;
  logic             we_q, we_d, ferr_q, ferr_d;
  logic             loading;
  logic [15:0]      len_next;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
  logic             cks_err_q, cks_err_d;
  localparam ld_state_t LD_AFTER_DATA = LD_CHECK;
`else
  localparam ld_state_t LD_AFTER_DATA = LD_DONE;
`endif

  always_comb begin
    rx_meta_d    = uart_rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    stop_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          // a start bit that is high again at mid-bit was only a glitch
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          stop_err_d   = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign loading  = (state_q != LD_IDLE) && (state_q != LD_DONE);
  assign len_next = {len_q[15:8], shift_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
    cks_err_d = cks_err_q;
`endif
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d = LD_LEN_HI;
          wc_d    = 16'd0;
          ferr_d  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
          xor_d     = 8'h00;
          cks_err_d = 1'b0;
`endif
        end
      end
      LD_LEN_HI: begin
        if (byte_valid_q) begin
          len_d[15:8] = shift_q;
          state_d     = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        if (byte_valid_q) begin
          len_d   = len_next;
          state_d = (len_next == 16'd0) ? LD_AFTER_DATA : LD_DATA_HI;
        end
      end
      LD_DATA_HI: begin
        if (byte_valid_q) begin
          hi_d    = shift_q;
          state_d = LD_DATA_LO;
`ifdef UART_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ shift_q;
`endif
        end
      end
      LD_DATA_LO: begin
        if (byte_valid_q) begin
          addr_d  = BASE_ADDR + wc_q;
          data_d  = {hi_q, shift_q};
          we_d    = 1'b1;
          state_d = LD_WRITE;
`ifdef UART_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ shift_q;
`endif
        end
      end
      LD_WRITE: begin
        wc_d    = wc_q + 16'd1;
        state_d = (wc_d == len_q) ? LD_AFTER_DATA : LD_DATA_HI;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (byte_valid_q) begin
          cks_err_d = (shift_q != xor_q);
          state_d   = LD_DONE;
        end
      end
`endif
      default: state_d = LD_IDLE;
    endcase
    // a corrupted byte is never used; an in-progress load is abandoned
    if (stop_err_q) begin
      ferr_d = 1'b1;
      if (loading) state_d = LD_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
      state_q      <= LD_IDLE;
      len_q        <= 16'd0;
      wc_q         <= 16'd0;
      addr_q       <= 16'd0;
      data_q       <= 16'd0;
      hi_q         <= 8'h00;
      we_q         <= 1'b0;
      ferr_q       <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_q        <= 8'h00;
      cks_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      stop_err_q   <= stop_err_d;
      state_q      <= state_d;
      len_q        <= len_d;
      wc_q         <= wc_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      hi_q         <= hi_d;
      we_q         <= we_d;
      ferr_q       <= ferr_d;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
      cks_err_q    <= cks_err_d;
`endif
    end
  end

  assign mem_address      = addr_q;
  assign mem_write_data   = data_q;
  assign mem_write_enable = we_q;
  assign busy             = loading;
  assign done             = (state_q == LD_DONE);
  assign word_count       = wc_q;
  assign frame_error      = ferr_q;
`ifdef UART_LOADER_CHECKSUM_EN
  assign checksum_error   = cks_err_q;
`else
  assign checksum_error   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_mem_loader: scoreboard bench for uart_mem_loader (BASE 0100 and FFFF).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_mem_loader;

  localparam int CPB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, uart_rx, start_a, start_b;
  logic [15:0] a_addr, a_data, a_wc, b_addr, b_data, b_wc;
  logic        a_we, a_busy, a_done, a_ferr, a_cks;
  logic        b_we, b_busy, b_done, b_ferr, b_cks;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0100)) dut_a (
    .clock(clock), .reset_n(reset_n), .uart_rx(uart_rx), .start(start_a),
    .mem_address(a_addr), .mem_write_data(a_data), .mem_write_enable(a_we),
    .busy(a_busy), .done(a_done), .word_count(a_wc),
    .frame_error(a_ferr), .checksum_error(a_cks)
  );

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF)) dut_b (
    .clock(clock), .reset_n(reset_n), .uart_rx(uart_rx), .start(start_b),
    .mem_address(b_addr), .mem_write_data(b_data), .mem_write_enable(b_we),
    .busy(b_busy), .done(b_done), .word_count(b_wc),
    .frame_error(b_ferr), .checksum_error(b_cks)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic        we_prev_a = 1'b0;
  logic        we_prev_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // write monitor: every enable must be a single-cycle pulse matching the queue head
  always @(negedge clock) begin
    if (a_we) begin
      check("a_we_pulse", {31'd0, we_prev_a}, 32'd0);
      if (exp_a.size() == 0) check("a_unexpected_wr", {31'd0, a_we}, 32'd0);
      else check("a_wr", {a_addr, a_data}, exp_a.pop_front());
    end
    if (b_we) begin
      check("b_we_pulse", {31'd0, we_prev_b}, 32'd0);
      if (exp_b.size() == 0) check("b_unexpected_wr", {31'd0, b_we}, 32'd0);
      else check("b_wr", {b_addr, b_data}, exp_b.pop_front());
    end
    we_prev_a = a_we;
    we_prev_b = b_we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_cks(input logic [7:0] b);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(b, 1'b1);
`else
    b = b;
`endif
  endtask

  task automatic pulse_start(input logic sel_b);
    @(negedge clock);
    if (sel_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel_b) begin
      check("b_busy_rise", {31'd0, b_busy}, 32'd1);
      check("b_entry_clear", {b_wc, 13'd0, b_done, b_ferr, b_cks}, 32'd0);
    end else begin
      check("a_busy_rise", {31'd0, a_busy}, 32'd1);
      check("a_entry_clear", {a_wc, 13'd0, a_done, a_ferr, a_cks}, 32'd0);
    end
  endtask

  task automatic wait_done(input logic sel_b, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sel_b ? b_done : a_done) break;
      @(negedge clock);
    end
    if (sel_b) check("b_done_timeout", {31'd0, b_done}, 32'd1);
    else check("a_done_timeout", {31'd0, a_done}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    uart_rx = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_addr_data", {a_addr, a_data}, 32'd0);
    check("reset_flags", {a_wc, 10'd0, a_we, a_busy, a_done, a_ferr, a_cks, 1'b0}, 32'd0);
    reset_n = 1'b1;
    repeat (CPB * 4) @(negedge clock);

    // two-word image
    pulse_start(1'b0);
    exp_a.push_back({16'h0100, 16'h1234});
    exp_a.push_back({16'h0101, 16'hABCD});
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    send_cks(8'h40);
    wait_done(1'b0, 200);
    check("t1_wc", {16'd0, a_wc}, 32'd2);
    check("t1_flags", {28'd0, a_busy, a_ferr, a_cks, a_done}, 32'd1);
    check("t1_pending", exp_a.size(), 32'd0);

    // empty image
    pulse_start(1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_cks(8'h00);
    wait_done(1'b0, 200);
    check("t2_wc", {16'd0, a_wc}, 32'd0);
    check("t2_cks", {31'd0, a_cks}, 32'd0);

    // bad stop bit on the first data byte aborts the load
    pulse_start(1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clock);
    check("t3_frame", {29'd0, a_ferr, a_busy, a_done}, 32'd4);

    // address wrap on the FFFF-based instance
    pulse_start(1'b1);
    exp_b.push_back({16'hFFFF, 16'h1111});
    exp_b.push_back({16'h0000, 16'h2222});
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1); send_byte(8'h22, 1'b1);
    send_cks(8'h00);
    wait_done(1'b1, 200);
    check("t4_wc", {16'd0, b_wc}, 32'd2);
    check("t4_flags", {29'd0, b_ferr, b_cks, b_busy}, 32'd0);
    check("t4_pending", exp_b.size(), 32'd0);

    // reset while waiting for the low byte of the second word
    pulse_start(1'b0);
    exp_a.push_back({16'h0100, 16'h1234});
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    uart_rx = 1'b0;
    repeat (CPB * 2) @(negedge clock);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("t5_rst_addr_data", {a_addr, a_data}, 32'd0);
    check("t5_rst_flags", {a_wc, 11'd0, a_we, a_busy, a_done, a_ferr, a_cks}, 32'd0);
    reset_n = 1'b1;
    repeat (CPB * 12) @(negedge clock);
    check("t5_idle_after", {30'd0, a_busy, a_done}, 32'd0);
    pulse_start(1'b0);
    exp_a.push_back({16'h0100, 16'h55AA});
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    send_cks(8'hFF);
    wait_done(1'b0, 200);
    check("t5_reload_wc", {16'd0, a_wc}, 32'd1);
    check("t5_pending", exp_a.size(), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    pulse_start(1'b0);
    exp_a.push_back({16'h0100, 16'h1234});
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h26, 1'b1);
    wait_done(1'b0, 200);
    check("t6_cks_good", {31'd0, a_cks}, 32'd0);
    pulse_start(1'b0);
    exp_a.push_back({16'h0100, 16'h1234});
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_done(1'b0, 200);
    check("t6_cks_bad", {31'd0, a_cks}, 32'd1);
    check("t6_pending", exp_a.size(), 32'd0);
`endif

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
